// File: rtl/rule_scheduler.sv
// Round-robin rule selector feeding system.io_en_a: fires one enabled guard per cycle for a step budget.
// Optional RULE_SCHED_LFSR_EN adds an LFSR-randomised search offset; default build is pure round-robin.
module rule_scheduler #(
   parameter int unsigned RULE_W    = 5,
   parameter int unsigned NUM_RULES = 32,
   parameter int unsigned STEP_W    = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_start,
   input  logic [STEP_W-1:0]    io_budget,
   input  logic                 io_hold,
   input  logic [NUM_RULES-1:0] io_guard,
   input  logic [15:0]          io_seed,
   output logic [RULE_W-1:0]    io_en_a,
   output logic                 io_en_valid,
   output logic                 io_busy,
   output logic                 io_done,
   output logic                 io_deadlock,
   output logic [STEP_W-1:0]    io_steps
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int unsigned RULE_SPACE = 1 << RULE_W;

   logic [1:0]            state_q, state_d;
   logic [RULE_W-1:0]     en_a_q, en_a_d;
   logic                  en_valid_q, en_valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  dead_q, dead_d;
   logic [STEP_W-1:0]     steps_q, steps_d;
   logic [STEP_W-1:0]     budget_q, budget_d;
   logic [RULE_W-1:0]     last_q, last_d;

   logic [RULE_SPACE-1:0] guard_ext;
   int unsigned           start_sum;
   int unsigned           cand;
   logic                  hit;
   logic [RULE_W-1:0]     pick;

`ifdef RULE_SCHED_LFSR_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic        lfsr_fb;
   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
`else
   logic unused_seed;
   assign unused_seed = ^io_seed;
`endif

   assign guard_ext = RULE_SPACE'(io_guard);

   // Circular first-set search starting just past the last fired rule
   always_comb begin
      hit  = 1'b0;
      pick = '0;
      cand = 0;
`ifdef RULE_SCHED_LFSR_EN
      start_sum = 32'(last_q) + 32'd1 + (32'(lfsr_q) % NUM_RULES);
`else
      start_sum = 32'(last_q) + 32'd1;
`endif
      if (start_sum >= NUM_RULES) start_sum = start_sum - NUM_RULES;
      for (int unsigned i = 0; i < NUM_RULES; i++) begin
         cand = start_sum + i;
         if (cand >= NUM_RULES) cand = cand - NUM_RULES;
         if (!hit && guard_ext[RULE_W'(cand)]) begin
            hit  = 1'b1;
            pick = RULE_W'(cand);
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      en_a_d     = en_a_q;
      en_valid_d = 1'b0;
      dead_d     = dead_q;
      steps_d    = steps_q;
      budget_d   = budget_q;
      last_d     = last_q;
`ifdef RULE_SCHED_LFSR_EN
      lfsr_d     = lfsr_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (io_start) begin
               steps_d  = '0;
               dead_d   = 1'b0;
               budget_d = io_budget;
`ifdef RULE_SCHED_LFSR_EN
               lfsr_d   = (io_seed == 16'h0) ? 16'hACE1 : io_seed;
`endif
               state_d  = (io_budget == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (io_hold) begin
               state_d = S_HOLD;
            end else if (hit) begin
               en_a_d     = pick;
               en_valid_d = 1'b1;
               last_d     = pick;
               steps_d    = steps_q + STEP_W'(1);
`ifdef RULE_SCHED_LFSR_EN
               lfsr_d     = {lfsr_q[14:0], lfsr_fb};
`endif
               if (steps_d == budget_q) state_d = S_DONE;
            end else begin
               dead_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_HOLD: begin
            if (!io_hold) state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         en_a_q     <= '0;
         en_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dead_q     <= 1'b0;
         steps_q    <= '0;
         budget_q   <= '0;
         last_q     <= RULE_W'(NUM_RULES - 1);
`ifdef RULE_SCHED_LFSR_EN
         lfsr_q     <= 16'hACE1;
`endif
      end else begin
         state_q    <= state_d;
         en_a_q     <= en_a_d;
         en_valid_q <= en_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         dead_q     <= dead_d;
         steps_q    <= steps_d;
         budget_q   <= budget_d;
         last_q     <= last_d;
`ifdef RULE_SCHED_LFSR_EN
         lfsr_q     <= lfsr_d;
`endif
      end
   end

   assign io_en_a     = en_a_q;
   assign io_en_valid = en_valid_q;
   assign io_busy     = busy_q;
   assign io_done     = done_q;
   assign io_deadlock = dead_q;
   assign io_steps    = steps_q;

endmodule

// File: tb/tb_rule_scheduler.sv
// Scoreboard bench for rule_scheduler: per-cycle expected outputs come from a behavioural model
// of the scheduling rules; a monitor compares them against the DUT one cycle later.
module tb_rule_scheduler;
   localparam int unsigned RULE_W    = 5;
   localparam int unsigned NUM_RULES = 32;
   localparam int unsigned STEP_W    = 16;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HOLD = 2;
   localparam int M_DONE = 3;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 io_start = 1'b0;
   logic [STEP_W-1:0]    io_budget = '0;
   logic                 io_hold = 1'b0;
   logic [NUM_RULES-1:0] io_guard = '0;
   logic [15:0]          io_seed = '0;
   logic [RULE_W-1:0]    io_en_a;
   logic                 io_en_valid;
   logic                 io_busy;
   logic                 io_done;
   logic                 io_deadlock;
   logic [STEP_W-1:0]    io_steps;

   rule_scheduler #(.RULE_W(RULE_W), .NUM_RULES(NUM_RULES), .STEP_W(STEP_W)) dut (
      .clock(clock), .reset(reset), .io_start(io_start), .io_budget(io_budget),
      .io_hold(io_hold), .io_guard(io_guard), .io_seed(io_seed), .io_en_a(io_en_a),
      .io_en_valid(io_en_valid), .io_busy(io_busy), .io_done(io_done),
      .io_deadlock(io_deadlock), .io_steps(io_steps)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        valid;
      int unsigned en_a;
      logic        busy;
      logic        done;
      logic        dead;
      int unsigned steps;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned fired[$];
   int          checks = 0;
   int          failures = 0;

   int          m_mode;
   int unsigned m_last, m_steps, m_budget, m_en_a;
   logic        m_dead;
   logic [15:0] m_lfsr;
   logic [15:0] cur_seed = 16'h0;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
      end
   endtask

   task automatic model_reset();
      m_mode   = M_IDLE;
      m_last   = NUM_RULES - 1;
      m_steps  = 0;
      m_budget = 0;
      m_en_a   = 0;
      m_dead   = 1'b0;
      m_lfsr   = 16'hACE1;
   endtask

   // Outcome of one clock edge given the inputs about to be sampled
   task automatic model_cycle(input logic st, input int unsigned bud, input logic hd,
                              input logic [NUM_RULES-1:0] g, input logic [15:0] seed);
      exp_t        e;
      logic        fire = 1'b0;
      int unsigned base;
      case (m_mode)
         M_IDLE, M_DONE: if (st) begin
            m_steps  = 0;
            m_dead   = 1'b0;
            m_budget = bud;
            m_lfsr   = (seed == 0) ? 16'hACE1 : seed;
            m_mode   = (bud == 0) ? M_DONE : M_RUN;
         end
         M_RUN: if (hd) begin
            m_mode = M_HOLD;
         end else begin
            base = m_last + 1;
`ifdef RULE_SCHED_LFSR_EN
            base = base + (int'(m_lfsr) % NUM_RULES);
`endif
            for (int unsigned off = 0; off < NUM_RULES && !fire; off++) begin
               if (g[(base + off) % NUM_RULES]) begin
                  fire   = 1'b1;
                  m_en_a = (base + off) % NUM_RULES;
               end
            end
            if (fire) begin
               m_last  = m_en_a;
               m_steps = m_steps + 1;
`ifdef RULE_SCHED_LFSR_EN
               m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
               if (m_steps == m_budget) m_mode = M_DONE;
            end else begin
               m_dead = 1'b1;
               m_mode = M_DONE;
            end
         end
         default: if (!hd) m_mode = M_RUN;
      endcase
      e.valid = fire;
      e.en_a  = m_en_a;
      e.busy  = (m_mode == M_RUN) || (m_mode == M_HOLD);
      e.done  = (m_mode == M_DONE);
      e.dead  = m_dead;
      e.steps = m_steps;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic st, input int unsigned bud, input logic hd,
                       input logic [NUM_RULES-1:0] g);
      @(negedge clock);
      io_start  = st;
      io_budget = STEP_W'(bud);
      io_hold   = hd;
      io_guard  = g;
      io_seed   = cur_seed;
      model_cycle(st, bud, hd, g, cur_seed);
   endtask

   task automatic do_reset();
      @(negedge clock);
      io_start = 1'b0;
      reset    = 1'b0;
      #1;
      chk("rst_en_a", io_en_a, 0);
      chk("rst_en_valid", io_en_valid, 0);
      chk("rst_busy", io_busy, 0);
      chk("rst_done", io_done, 0);
      chk("rst_deadlock", io_deadlock, 0);
      chk("rst_steps", io_steps, 0);
      model_reset();
      exp_q.delete();
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic check_fired(input string name, input int unsigned want[$]);
      chk({name, "_count"}, fired.size(), want.size());
      for (int i = 0; i < want.size() && i < fired.size(); i++) chk(name, fired[i], want[i]);
      fired.delete();
   endtask

   // Monitor: compare every presented output against the scoreboard
   always @(posedge clock) begin : monitor
      exp_t e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("en_valid", io_en_valid, e.valid);
         chk("en_a", io_en_a, e.en_a);
         chk("busy", io_busy, e.busy);
         chk("done", io_done, e.done);
         chk("deadlock", io_deadlock, e.dead);
         chk("steps", io_steps, e.steps);
         if (io_en_valid) fired.push_back(io_en_a);
      end
   end

`ifdef RULE_SCHED_LFSR_EN
   task automatic seeded_run(input logic [15:0] seed, output int unsigned seq[$]);
      do_reset();
      cur_seed = seed;
      fired.delete();
      step(1'b1, 8, 1'b0, 32'hFFFF_FFFF);
      repeat (8) step(1'b0, 0, 1'b0, 32'hFFFF_FFFF);
      step(1'b0, 0, 1'b0, 32'hFFFF_FFFF);
      seq = fired;
      fired.delete();
      cur_seed = 16'h0;
   endtask
`endif

   initial begin
      int unsigned want[$];
      int unsigned bud;
      int unsigned r;
      logic [NUM_RULES-1:0] g;
      model_reset();
      #2 reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("init_en_a", io_en_a, 0);
      chk("init_en_valid", io_en_valid, 0);
      chk("init_busy", io_busy, 0);
      chk("init_done", io_done, 0);
      chk("init_deadlock", io_deadlock, 0);
      chk("init_steps", io_steps, 0);
      reset = 1'b1;
      step(1'b0, 0, 1'b0, '0);

      // Basic round-robin over guards {0,1,4}
      fired.delete();
      step(1'b1, 4, 1'b0, 32'h13);
      repeat (4) step(1'b0, 0, 1'b0, 32'h13);
      step(1'b0, 0, 1'b0, 32'h13);
      chk("t1_done", io_done, 1);
      chk("t1_steps", io_steps, 4);
      chk("t1_deadlock", io_deadlock, 0);
      want = '{0, 1, 4, 0};
      check_fired("t1_seq", want);

      // Single guard at the top index: pointer wrap
      step(1'b1, 3, 1'b0, 32'h8000_0000);
      repeat (3) step(1'b0, 0, 1'b0, 32'h8000_0000);
      step(1'b0, 0, 1'b0, 32'h8000_0000);
      chk("t2_steps", io_steps, 3);
      want = '{31, 31, 31};
      check_fired("t2_seq", want);

      // Deadlock after two firings
      step(1'b1, 10, 1'b0, 32'h5);
      repeat (2) step(1'b0, 0, 1'b0, 32'h5);
      step(1'b0, 0, 1'b0, 32'h0);
      step(1'b0, 0, 1'b0, 32'h0);
      chk("t3_valid", io_en_valid, 0);
      chk("t3_deadlock", io_deadlock, 1);
      chk("t3_done", io_done, 1);
      chk("t3_steps", io_steps, 2);
      want = '{0, 2};
      check_fired("t3_seq", want);

      // Hold mid-run freezes firings and the step counter
      step(1'b1, 6, 1'b0, 32'h6);
      repeat (3) step(1'b0, 0, 1'b0, 32'h6);
      repeat (2) step(1'b0, 0, 1'b1, 32'h6);
      chk("t4_hold_steps", io_steps, 3);
      chk("t4_hold_valid", io_en_valid, 0);
      chk("t4_hold_busy", io_busy, 1);
      step(1'b1, 0, 1'b1, 32'h6);
      step(1'b0, 0, 1'b0, 32'h6);
      repeat (3) step(1'b0, 0, 1'b0, 32'h6);
      step(1'b0, 0, 1'b0, 32'h6);
      chk("t4_done", io_done, 1);
      chk("t4_steps", io_steps, 6);
      want = '{1, 2, 1, 2, 1, 2};
      check_fired("t4_seq", want);

      // Reset mid-run, then zero-budget start
      step(1'b1, 10, 1'b0, 32'hFF);
      repeat (2) step(1'b0, 0, 1'b0, 32'hFF);
      do_reset();
      fired.delete();
      step(1'b1, 0, 1'b0, 32'hFF);
      step(1'b0, 0, 1'b0, 32'hFF);
      chk("t5_done", io_done, 1);
      chk("t5_steps", io_steps, 0);
      chk("t5_deadlock", io_deadlock, 0);
      want = {};
      check_fired("t5_seq", want);

      // Randomised runs against the model
      for (int run = 0; run < 40; run++) begin
         cur_seed = 16'($urandom);
         bud = $urandom_range(0, 20);
         step(1'b1, bud, 1'b0, NUM_RULES'($urandom));
         for (int c = 0; c < 200 && m_mode != M_DONE; c++) begin
            r = $urandom_range(0, 19);
            g = (r == 0) ? '0 : (r < 8) ? NUM_RULES'($urandom & $urandom & $urandom)
                                        : NUM_RULES'($urandom);
            step($urandom_range(0, 7) == 0, $urandom_range(0, 5), $urandom_range(0, 4) == 0, g);
         end
         step(1'b0, 0, 1'b0, '0);
         if ($urandom_range(0, 5) == 0) do_reset();
      end
      fired.delete();

`ifdef RULE_SCHED_LFSR_EN
      begin
         int unsigned seq_a[$], seq_b[$], seq_c[$];
         int diffs = 0;
         seeded_run(16'h0000, seq_a);
         seeded_run(16'hACE1, seq_b);
         seeded_run(16'h1234, seq_c);
         chk("lfsr_len", seq_b.size(), seq_a.size());
         for (int i = 0; i < seq_a.size() && i < seq_b.size(); i++) chk("lfsr_same_seed", seq_b[i], seq_a[i]);
         for (int i = 0; i < seq_a.size() && i < seq_c.size(); i++) if (seq_a[i] != seq_c[i]) diffs++;
         chk("lfsr_seed_differs", diffs != 0, 1);
      end
`endif

      step(1'b0, 0, 1'b0, '0);
      @(negedge clock);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
